note_sequencer: RTL and testbench

Song-level controller for the note timer datapath. Walks a song table of (time, key-mask) entries and gates the timer's count enable. Holds the timer at each note time until the required keys are down, then advances to the next entry. Reports hit/late statistics and song completion to the display/score logic.

---
 rtl/noctavia_pkg.sv | 31 +++
 rtl/note_sequencer_song_rom.sv | 70 +++++++
 rtl/note_sequencer.sv | 179 +++++++++++++++++
 tb/tb_note_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noctavia_pkg.sv
// Shared types and constants for the note sequencer slice.
package noctavia_pkg;

  localparam int unsigned TIME_W = 21;
  localparam int unsigned KEY_W  = 5;

  localparam int unsigned KEY_C = 0;
  localparam int unsigned KEY_D = 1;
  localparam int unsigned KEY_E = 2;
  localparam int unsigned KEY_F = 3;
  localparam int unsigned KEY_G = 4;

  typedef enum logic [1:0] {IDLE, RUN, WAIT_KEY, DONE} seq_state_t;

  typedef struct packed {
    logic [TIME_W-1:0] etime;
    logic [KEY_W-1:0]  mask;
  } song_entry_t;

  function automatic logic [KEY_W-1:0] key_bit(input int unsigned pos);
    return KEY_W'(1) << pos;
  endfunction

  function automatic song_entry_t ent(input int unsigned t, input logic [KEY_W-1:0] m);
    song_entry_t e;
    e.etime = TIME_W'(t);
    e.mask  = m;
    return e;
  endfunction

endpackage

// File: rtl/note_sequencer_song_rom.sv
// Song table: note time and required key mask per entry, 44 entries.
module song_rom
  import noctavia_pkg::*;
#(
  parameter int unsigned IDX_W = 6
) (
  input  logic [IDX_W-1:0] idx_i,
  output song_entry_t      entry_o
);

  localparam logic [KEY_W-1:0] C = key_bit(KEY_C);
  localparam logic [KEY_W-1:0] D = key_bit(KEY_D);
  localparam logic [KEY_W-1:0] E = key_bit(KEY_E);
  localparam logic [KEY_W-1:0] F = key_bit(KEY_F);
  localparam logic [KEY_W-1:0] G = key_bit(KEY_G);

  // Table lookup; unused indices read as an unreachable time with no keys
  always_comb begin
    entry_o = ent(0, '0);
    entry_o.etime = '1;
    case (int'(idx_i))
      0:  entry_o = ent(417,  C);
      1:  entry_o = ent(460,  E);
      2:  entry_o = ent(503,  D);
      3:  entry_o = ent(546,  F);
      4:  entry_o = ent(589,  G);
      5:  entry_o = ent(632,  C | E);
      6:  entry_o = ent(675,  E);
      7:  entry_o = ent(718,  F | G);
      8:  entry_o = ent(761,  C);
      9:  entry_o = ent(804,  D);
      10: entry_o = ent(847,  E);
      11: entry_o = ent(890,  F);
      12: entry_o = ent(933,  G);
      13: entry_o = ent(976,  C | E | G);
      14: entry_o = ent(1019, D);
      15: entry_o = ent(1062, F);
      16: entry_o = ent(1105, E);
      17: entry_o = ent(1148, C);
      18: entry_o = ent(1191, D | F);
      19: entry_o = ent(1234, G);
      20: entry_o = ent(1277, E);
      21: entry_o = ent(1320, C);
      22: entry_o = ent(1363, D);
      23: entry_o = ent(1406, E | G);
      24: entry_o = ent(1449, F);
      25: entry_o = ent(1492, G);
      26: entry_o = ent(1535, C);
      27: entry_o = ent(1578, C | E);
      28: entry_o = ent(1621, D);
      29: entry_o = ent(1664, E);
      30: entry_o = ent(1707, F | G);
      31: entry_o = ent(1750, G);
      32: entry_o = ent(1793, E);
      33: entry_o = ent(1836, D);
      34: entry_o = ent(1879, C);
      35: entry_o = ent(1922, C | E | G);
      36: entry_o = ent(1965, F);
      37: entry_o = ent(2008, E);
      38: entry_o = ent(2051, D);
      39: entry_o = ent(2094, D | F);
      40: entry_o = ent(2137, C);
      41: entry_o = ent(2180, E);
      42: entry_o = ent(2223, G);
      43: entry_o = ent(2266, C | E | G);
      default: ;
    endcase
  end

endmodule

// File: rtl/note_sequencer.sv
// Song-level controller: walks the song table, gates the note timer,
// scores hits and late hits. Optional skip-on-stall: NOTE_SKIP_TIMEOUT_EN.
module note_sequencer
  import noctavia_pkg::*;
#(
  parameter int unsigned NUM_NOTES = 44,
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned CNT_W     = 8
`ifdef NOTE_SKIP_TIMEOUT_EN
  , parameter int unsigned STALL_MAX = 1023
`endif
) (
  input  logic              Noteclk,
  input  logic              reset,
  input  logic              start,
  input  logic [KEY_W-1:0]  keys,
  input  logic [TIME_W-1:0] note_time,
  output logic              timer_en,
  output logic              timer_clr,
  output logic [IDX_W-1:0]  note_idx,
  output logic [KEY_W-1:0]  expected_mask,
  output logic              waiting,
  output logic              hit_pulse,
  output logic              late_pulse,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  late_count,
  output logic              song_done
`ifdef NOTE_SKIP_TIMEOUT_EN
  , output logic             miss_pulse,
  output logic [CNT_W-1:0]  miss_count
`endif
);

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] hit_q, hit_d, late_q, late_d;
  logic             hit_p_q, hit_p_d, late_p_q, late_p_d, clr_q, clr_d;
  logic             keys_ok, due, last, resolve;
  song_entry_t      entry;

`ifdef NOTE_SKIP_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0]   miss_q, miss_d;
  logic               miss_p_q, miss_p_d;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  song_rom #(.IDX_W(IDX_W)) u_rom (
    .idx_i   (idx_q),
    .entry_o (entry)
  );

  assign keys_ok = (keys & entry.mask) == entry.mask;
  // While timer_clr is out the timer still shows the previous song's value
  assign due     = !clr_q && (note_time >= entry.etime);
  assign last    = (idx_q == IDX_W'(NUM_NOTES - 1));

  // Next-state, scoring and timer enable
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hit_d    = hit_q;
    late_d   = late_q;
    hit_p_d  = 1'b0;
    late_p_d = 1'b0;
    clr_d    = 1'b0;
    resolve  = 1'b0;
    timer_en = 1'b0;
`ifdef NOTE_SKIP_TIMEOUT_EN
    stall_d  = stall_q;
    miss_d   = miss_q;
    miss_p_d = 1'b0;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          hit_d   = '0;
          late_d  = '0;
          clr_d   = 1'b1;
`ifdef NOTE_SKIP_TIMEOUT_EN
          miss_d  = '0;
`endif
        end
      end
      RUN: begin
        timer_en = !(due && !keys_ok);
        if (due) begin
          if (keys_ok) begin
            hit_d   = sat_inc(hit_q);
            hit_p_d = 1'b1;
            resolve = 1'b1;
          end else begin
            state_d = WAIT_KEY;
`ifdef NOTE_SKIP_TIMEOUT_EN
            stall_d = '0;
`endif
          end
        end
      end
      WAIT_KEY: begin
        if (keys_ok) begin
          late_d   = sat_inc(late_q);
          late_p_d = 1'b1;
          resolve  = 1'b1;
        end
`ifdef NOTE_SKIP_TIMEOUT_EN
        else if (stall_q == STALL_W'(STALL_MAX - 1)) begin
          miss_d   = sat_inc(miss_q);
          miss_p_d = 1'b1;
          resolve  = 1'b1;
        end else begin
          stall_d = stall_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (resolve) begin
      if (last) begin
        state_d = DONE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = RUN;
      end
    end
  end

  // State and score registers
  always_ff @(posedge Noteclk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      hit_q    <= '0;
      late_q   <= '0;
      hit_p_q  <= 1'b0;
      late_p_q <= 1'b0;
      clr_q    <= 1'b0;
`ifdef NOTE_SKIP_TIMEOUT_EN
      stall_q  <= '0;
      miss_q   <= '0;
      miss_p_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hit_q    <= hit_d;
      late_q   <= late_d;
      hit_p_q  <= hit_p_d;
      late_p_q <= late_p_d;
      clr_q    <= clr_d;
`ifdef NOTE_SKIP_TIMEOUT_EN
      stall_q  <= stall_d;
      miss_q   <= miss_d;
      miss_p_q <= miss_p_d;
`endif
    end
  end

  assign timer_clr     = clr_q;
  assign note_idx      = idx_q;
  assign expected_mask = entry.mask;
  assign waiting       = (state_q == WAIT_KEY);
  assign song_done     = (state_q == DONE);
  assign hit_pulse     = hit_p_q;
  assign late_pulse    = late_p_q;
  assign hit_count     = hit_q;
  assign late_count    = late_q;
`ifdef NOTE_SKIP_TIMEOUT_EN
  assign miss_pulse    = miss_p_q;
  assign miss_count    = miss_q;
`endif

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: table vectors, directed corner sequences and a
// randomized run against a behavioural song/score model.
module tb_note_sequencer;
  import noctavia_pkg::*;

  localparam int NN = 44;
`ifdef NOTE_SKIP_TIMEOUT_EN
  localparam int STALL = 4;
`endif

  logic              Noteclk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [KEY_W-1:0]  keys = '0;
  logic [TIME_W-1:0] note_time = '0;
  logic              timer_en, timer_clr, waiting, hit_pulse, late_pulse, song_done;
  logic [5:0]        note_idx;
  logic [4:0]        expected_mask;
  logic [7:0]        hit_count, late_count;
`ifdef NOTE_SKIP_TIMEOUT_EN
  logic              miss_pulse;
  logic [7:0]        miss_count;
`endif

  always #5 Noteclk = ~Noteclk;

`ifdef NOTE_SKIP_TIMEOUT_EN
  note_sequencer #(.STALL_MAX(STALL)) dut (
`else
  note_sequencer dut (
`endif
    .Noteclk(Noteclk), .reset(reset), .start(start), .keys(keys),
    .note_time(note_time), .timer_en(timer_en), .timer_clr(timer_clr),
    .note_idx(note_idx), .expected_mask(expected_mask), .waiting(waiting),
    .hit_pulse(hit_pulse), .late_pulse(late_pulse), .hit_count(hit_count),
    .late_count(late_count), .song_done(song_done)
`ifdef NOTE_SKIP_TIMEOUT_EN
    , .miss_pulse(miss_pulse), .miss_count(miss_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Song data: times are 417 + 43*i; masks as bit vectors (C=1 .. G=16)
  int mask_tab [NN] = '{1, 4, 2, 8, 16, 5, 4, 24, 1, 2, 4, 8, 16, 21, 2, 8,
                        4, 1, 10, 16, 4, 1, 2, 20, 8, 16, 1, 5, 2, 4, 24, 16,
                        4, 2, 1, 21, 8, 4, 2, 10, 1, 4, 16, 21};
  function automatic int ent_time(int i);
    return 417 + 43 * i;
  endfunction

  // Behavioural model of the song player
  bit m_play, m_stuck, m_fin, m_hp, m_lp, m_clr;
  int m_idx, m_hits, m_lates;
`ifdef NOTE_SKIP_TIMEOUT_EN
  bit m_mp;
  int m_miss, m_wait;
`endif
  bit auto_timer = 1'b0;

  function automatic bit m_ok();
    return (int'(keys) & mask_tab[m_idx]) == mask_tab[m_idx];
  endfunction
  function automatic bit m_due();
    return m_play && !m_stuck && !m_clr && (int'(note_time) >= ent_time(m_idx));
  endfunction
  function automatic bit m_en();
    return m_play && !m_stuck && !(m_due() && !m_ok());
  endfunction
  function automatic int sat(int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic m_reset();
    m_play = 0; m_stuck = 0; m_fin = 0; m_hp = 0; m_lp = 0; m_clr = 0;
    m_idx = 0; m_hits = 0; m_lates = 0;
`ifdef NOTE_SKIP_TIMEOUT_EN
    m_mp = 0; m_miss = 0; m_wait = 0;
`endif
  endtask

  task automatic m_edge();
    bit ok, due, adv;
    if (!reset) begin
      m_reset();
      return;
    end
    ok = m_ok(); due = m_due(); adv = 0;
    m_hp = 0; m_lp = 0; m_clr = 0;
`ifdef NOTE_SKIP_TIMEOUT_EN
    m_mp = 0;
`endif
    if (!m_play) begin
      if (start) begin
        m_play = 1; m_fin = 0; m_stuck = 0; m_idx = 0;
        m_hits = 0; m_lates = 0; m_clr = 1;
`ifdef NOTE_SKIP_TIMEOUT_EN
        m_miss = 0;
`endif
      end
    end else if (!m_stuck) begin
      if (due) begin
        if (ok) begin
          m_hits = sat(m_hits + 1); m_hp = 1; adv = 1;
        end else begin
          m_stuck = 1;
`ifdef NOTE_SKIP_TIMEOUT_EN
          m_wait = 0;
`endif
        end
      end
    end else begin
      if (ok) begin
        m_lates = sat(m_lates + 1); m_lp = 1; adv = 1; m_stuck = 0;
      end
`ifdef NOTE_SKIP_TIMEOUT_EN
      else begin
        m_wait++;
        if (m_wait == STALL) begin
          m_miss = sat(m_miss + 1); m_mp = 1; adv = 1; m_stuck = 0;
        end
      end
`endif
    end
    if (adv) begin
      if (m_idx == NN - 1) begin
        m_play = 0; m_fin = 1;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("timer_en", int'(timer_en), int'(m_en()));
    chk("timer_clr", int'(timer_clr), int'(m_clr));
    chk("note_idx", int'(note_idx), m_idx);
    chk("expected_mask", int'(expected_mask), mask_tab[m_idx]);
    chk("waiting", int'(waiting), int'(m_stuck));
    chk("hit_pulse", int'(hit_pulse), int'(m_hp));
    chk("late_pulse", int'(late_pulse), int'(m_lp));
    chk("hit_count", int'(hit_count), m_hits);
    chk("late_count", int'(late_count), m_lates);
    chk("song_done", int'(song_done), int'(m_fin));
`ifdef NOTE_SKIP_TIMEOUT_EN
    chk("miss_pulse", int'(miss_pulse), int'(m_mp));
    chk("miss_count", int'(miss_count), m_miss);
`endif
  endtask

  task automatic cyc_pre();
    @(negedge Noteclk);
    check_all();
  endtask

  task automatic cyc_post();
    bit en_now, clr_now;
    en_now = m_en(); clr_now = m_clr;
    @(posedge Noteclk);
    m_edge();
    #1;
    if (auto_timer) begin
      if (clr_now) note_time = '0;
      else if (en_now) note_time = note_time + 1'b1;
    end
  endtask

  task automatic cyc();
    cyc_pre();
    cyc_post();
  endtask

  typedef struct {
    bit st; logic [4:0] k; int t;
    bit en; bit wt; int idx; bit clr; bit hp; bit lp; int hc; int lc;
  } vec_t;

  vec_t vt [13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          st k        t    en wt idx clr hp lp hc lc
    vt[0]  = '{0, 5'b00000, 0,   0, 0, 0,  0,  0, 0, 0, 0};
    vt[1]  = '{1, 5'b00000, 0,   0, 0, 0,  0,  0, 0, 0, 0};
    vt[2]  = '{0, 5'b00000, 0,   1, 0, 0,  1,  0, 0, 0, 0};
    vt[3]  = '{0, 5'b00000, 410, 1, 0, 0,  0,  0, 0, 0, 0};
    vt[4]  = '{0, 5'b00000, 420, 0, 0, 0,  0,  0, 0, 0, 0};
    vt[5]  = '{0, 5'b00000, 420, 0, 1, 0,  0,  0, 0, 0, 0};
    vt[6]  = '{0, 5'b00001, 420, 0, 1, 0,  0,  0, 0, 0, 0};
    vt[7]  = '{0, 5'b00000, 420, 1, 0, 1,  0,  0, 1, 0, 1};
    vt[8]  = '{0, 5'b00100, 459, 1, 0, 1,  0,  0, 0, 0, 1};
    vt[9]  = '{0, 5'b00100, 460, 1, 0, 1,  0,  0, 0, 0, 1};
    vt[10] = '{0, 5'b00100, 460, 1, 0, 2,  0,  1, 0, 1, 1};
    vt[11] = '{1, 5'b00100, 461, 1, 0, 2,  0,  0, 0, 1, 1};
    vt[12] = '{0, 5'b00000, 461, 1, 0, 2,  0,  0, 0, 1, 1};

    m_reset();
    cyc(); cyc();
    reset = 1'b1;

    // Table-driven opening: start, jumped-over due time, late hit, on-time hit
    foreach (vt[i]) begin
      start = vt[i].st; keys = vt[i].k; note_time = TIME_W'(vt[i].t);
      cyc_pre();
      chk($sformatf("vec%0d_en", i), int'(timer_en), int'(vt[i].en));
      chk($sformatf("vec%0d_wait", i), int'(waiting), int'(vt[i].wt));
      chk($sformatf("vec%0d_idx", i), int'(note_idx), vt[i].idx);
      chk($sformatf("vec%0d_clr", i), int'(timer_clr), int'(vt[i].clr));
      chk($sformatf("vec%0d_hp", i), int'(hit_pulse), int'(vt[i].hp));
      chk($sformatf("vec%0d_lp", i), int'(late_pulse), int'(vt[i].lp));
      chk($sformatf("vec%0d_hc", i), int'(hit_count), vt[i].hc);
      chk($sformatf("vec%0d_lc", i), int'(late_count), vt[i].lc);
      cyc_post();
    end
    start = 1'b0;

    // Hit entries 2..6, then chord F|G at entry 7 with only F held
    keys = 5'b11111;
    for (int b = 0; b < 40 && m_idx < 7; b++) begin
      note_time = TIME_W'(ent_time(m_idx));
      cyc();
    end
    chk("reach7_idx", int'(note_idx), 7);
    keys = 5'b01000; note_time = TIME_W'(718);
    cyc();
    cyc_pre();
    chk("chord_wait", int'(waiting), 1);
    chk("chord_en", int'(timer_en), 0);
    cyc_post();
    keys = 5'b11000;
    cyc();
    cyc_pre();
    chk("chord_late", int'(late_pulse), 1);
    chk("chord_idx", int'(note_idx), 8);
    chk("chord_lc", int'(late_count), 2);
    chk("chord_hc", int'(hit_count), 6);
    cyc_post();

    // Full song with every key held, timer driven by the enable
    reset = 1'b0; m_reset(); #1; reset = 1'b1;
    auto_timer = 1'b1; note_time = '0; keys = 5'b11111;
    start = 1'b1; cyc(); start = 1'b0;
    for (int n = 0; n < 4000 && !song_done; n++) cyc();
    cyc_pre();
    chk("full_done", int'(song_done), 1);
    chk("full_hits", int'(hit_count), 44);
    chk("full_lates", int'(late_count), 0);
    chk("full_idx", int'(note_idx), 43);
    chk("full_en", int'(timer_en), 0);
    cyc_post();
    start = 1'b1; cyc(); start = 1'b0;
    cyc_pre();
    chk("restart_clr", int'(timer_clr), 1);
    chk("restart_hc", int'(hit_count), 0);
    chk("restart_idx", int'(note_idx), 0);
    cyc_post();

    // Earn one hit, then stall in WAIT_KEY and reset asynchronously
    for (int n = 0; n < 1000 && m_idx < 1; n++) cyc();
    keys = '0;
    for (int n = 0; n < 200 && !waiting; n++) cyc();
    chk("pre_rst_wait", int'(waiting), 1);
    chk("pre_rst_hc", int'(hit_count), 1);
    @(negedge Noteclk); #2;
    reset = 1'b0; m_reset(); #1;
    chk("rst_wait", int'(waiting), 0);
    chk("rst_hc", int'(hit_count), 0);
    chk("rst_idx", int'(note_idx), 0);
    chk("rst_en", int'(timer_en), 0);
    cyc_post();
    cyc();
    reset = 1'b1;

`ifdef NOTE_SKIP_TIMEOUT_EN
    // Stall with no keys until the skip timeout fires
    note_time = '0; keys = '0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int n = 0; n < 1000 && !miss_pulse; n++) cyc();
    chk("miss_seen", int'(miss_pulse), 1);
    chk("miss_cnt", int'(miss_count), 1);
    chk("miss_idx", int'(note_idx), 1);
`endif

    // Randomized play against the model
    for (int n = 0; n < 15000; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) keys = 5'(mask_tab[m_idx]);
      else if (r < 6) keys = 5'b11111;
      else if (r < 8) keys = 5'($urandom_range(0, 31));
      else keys = '0;
      start = ($urandom_range(0, 199) == 0) || (m_fin && $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) note_time = note_time + TIME_W'($urandom_range(0, 30));
      if ($urandom_range(0, 2999) == 0) begin
        reset = 1'b0; m_reset();
      end else begin
        reset = 1'b1;
      end
      cyc();
    end
    reset = 1'b1;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
